clk_ratio_gen: RTL

- Generates a divided clock-like signal (`div_clk`) from the single fast clock `clk`.
- The divide ratio is programmable through a valid/ready configuration port.
- `rise_stb` and `fall_stb` are single-cycle strobes, and `periods` is a running period counter.
- It is the producer side of clock-ratio measurement: downstream logic counts `clk` against `div_clk` edges and checks the configured ratio.

---
 rtl/clk_ratio_gen_pkg.sv | 41 ++++
 rtl/clk_ratio_gen_if.sv | 34 +++
 rtl/clk_ratio_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/clk_ratio_gen_pkg.sv
// ============================================================================
// Module  : clk_ratio_pkg
// Brief   : Shared types, state encoding and divisor helpers for clk_ratio_gen.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package clk_ratio_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HIGH = ST_HIGH,
        LOW  = ST_LOW
    } state_e;

    localparam logic [31:0] DIV_MIN = 32'd2;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } phase_t;

    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        return (n < DIV_MIN) ? DIV_MIN : n;
    endfunction

    // Odd divisors put the extra cycle in the high phase.
    function automatic phase_t phase_len(input logic [31:0] n);
        phase_t p;
        p.lo = n >> 1;
        p.hi = n - p.lo;
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_ratio_gen_if.sv
// ============================================================================
// Module  : clk_ratio_gen_if
// Brief   : Control, configuration and divided-clock bundle for clk_ratio_gen.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface clk_ratio_gen_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 32
);
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             div_clk;
    logic             rise_stb;
    logic             fall_stb;
    logic [CNT_W-1:0] periods;
    logic             running;

    modport master (
        output start, stop, cfg_valid, cfg_div,
        input  cfg_ready, div_clk, rise_stb, fall_stb, periods, running
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_div,
        output cfg_ready, div_clk, rise_stb, fall_stb, periods, running
    );
endinterface

`default_nettype wire

// File: rtl/clk_ratio_gen.sv
// ============================================================================
// Module  : clk_ratio_gen
// Brief   : Programmable divided-clock generator with edge strobes and period count.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module clk_ratio_gen
    import clk_ratio_pkg::*;
#(
    parameter int DIV_W       = 16,   // 2..32
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    clk_ratio_gen_if.slave bus
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             stop_pend_q, stop_pend_d;
    logic             div_clk_q, div_clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             running_q, running_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic [CNT_W-1:0] periods_q, periods_d;

    logic             w_xfer;
    logic [DIV_W-1:0] w_cfg_clamped;
    logic [DIV_W-1:0] w_load_div;
    logic [DIV_W-1:0] w_ph_div;
    phase_t           w_ph;

    assign w_xfer        = bus.cfg_valid && cfg_ready_q;
    assign w_cfg_clamped = DIV_W'(clamp_div(32'(bus.cfg_div)));
    // Divisor for the period about to start; a pending value is never present in IDLE.
    assign w_load_div    = w_xfer ? w_cfg_clamped : (pend_vld_q ? pend_q : active_q);
    assign w_ph_div      = (state_q == HIGH) ? active_q : w_load_div;
    assign w_ph          = phase_len(32'(w_ph_div));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        stop_pend_d = stop_pend_q;
        div_clk_d   = div_clk_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        running_d   = running_q;
        cfg_ready_d = cfg_ready_q;
        periods_d   = periods_q;

        case (state_q)
            IDLE: begin
                if (w_xfer) active_d = w_cfg_clamped;
                if (bus.start) begin
                    state_d     = HIGH;
                    cnt_d       = DIV_W'(w_ph.hi - 32'd1);
                    div_clk_d   = 1'b1;
                    rise_d      = 1'b1;
                    running_d   = 1'b1;
                    stop_pend_d = 1'b0;
                    periods_d   = CNT_W'(1);
                end
            end
            HIGH, LOW: begin
                if (bus.stop) stop_pend_d = 1'b1;
                if (w_xfer) begin
                    pend_d      = w_cfg_clamped;
                    pend_vld_d  = 1'b1;
                    cfg_ready_d = 1'b0;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else if (state_q == HIGH) begin
                    state_d   = LOW;
                    cnt_d     = DIV_W'(w_ph.lo - 32'd1);
                    div_clk_d = 1'b0;
                    fall_d    = 1'b1;
                end else begin
                    // Period boundary: the new divisor takes over only here.
                    active_d    = w_load_div;
                    pend_vld_d  = 1'b0;
                    cfg_ready_d = 1'b1;
                    if (stop_pend_q || bus.stop) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        running_d   = 1'b0;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d   = HIGH;
                        cnt_d     = DIV_W'(w_ph.hi - 32'd1);
                        div_clk_d = 1'b1;
                        rise_d    = 1'b1;
                        periods_d = periods_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                div_clk_d = 1'b0;
                running_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            active_q    <= DIV_W'(DEFAULT_DIV);
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            div_clk_q   <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            running_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            periods_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            stop_pend_q <= stop_pend_d;
            div_clk_q   <= div_clk_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            running_q   <= running_d;
            cfg_ready_q <= cfg_ready_d;
            periods_q   <= periods_d;
        end
    end

    assign bus.div_clk   = div_clk_q;
    assign bus.rise_stb  = rise_q;
    assign bus.fall_stb  = fall_q;
    assign bus.running   = running_q;
    assign bus.cfg_ready = cfg_ready_q;
    assign bus.periods   = periods_q;

endmodule

`default_nettype wire
